// File: rtl/traffic_light_seq.sv
// Run-time RED -> GREEN -> YELLOW sequencer with programmable phase durations and countdown.
// Optional: define TRAFFIC_BLINK_YELLOW_EN to blink the yellow lamp once per tick while in CONFIG.
module traffic_light_seq #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8,
    parameter int R_DEF    = 30,
    parameter int G_DEF    = 25,
    parameter int Y_DEF    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             first_in,
    input  logic             control_r_in,
    input  logic             control_y_in,
    input  logic             control_g_in,
    input  logic [CNT_W-1:0] dur_in,
    output logic             light_r,
    output logic             light_y,
    output logic             light_g,
    output logic [CNT_W-1:0] remain,
    output logic [1:0]       state_out
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_CONFIG = 2'd0,
        S_RED    = 2'd1,
        S_GREEN  = 2'd2,
        S_YELLOW = 2'd3
    } state_t;

    // A zero-second phase would never show on the display, so it is held at one second.
    function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_remain;
    logic [PRE_W-1:0] r_presc;
    logic             r_light_r;
    logic             r_light_y;
    logic             r_light_g;
    logic [CNT_W-1:0] r_dur_r;
    logic [CNT_W-1:0] r_dur_g;
    logic [CNT_W-1:0] r_dur_y;
    logic             r_ctl_r_p0;
    logic             r_ctl_g_p0;
    logic             r_ctl_y_p0;
    logic             r_ctl_r_p1;
    logic             r_ctl_g_p1;
    logic             r_ctl_y_p1;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_remain_nxt;
    logic [PRE_W-1:0] w_presc_nxt;
    logic             w_lr_nxt;
    logic             w_ly_nxt;
    logic             w_lg_nxt;
    logic             w_in_cfg;
    logic             w_cfg_change;
    logic             w_tick;
    logic             w_presc_run;
    logic             w_ly_cfg;
    logic             w_edge_r;
    logic             w_edge_g;
    logic             w_edge_y;
    logic             w_ld_r;
    logic             w_ld_g;
    logic             w_ld_y;

    assign w_in_cfg     = (r_state == S_CONFIG);
    assign w_cfg_change = (first_in != w_in_cfg);
    assign w_tick       = (r_presc == PRE_LAST);

`ifdef TRAFFIC_BLINK_YELLOW_EN
    assign w_presc_run = 1'b1;
    assign w_ly_cfg    = w_in_cfg ? (r_light_y ^ w_tick) : 1'b1;
`else
    assign w_presc_run = !w_in_cfg;
    assign w_ly_cfg    = 1'b0;
`endif

    // Stage p0 -> p1: registered strobes, loads act on a rising edge of the registered copy
    assign w_edge_r = r_ctl_r_p0 & ~r_ctl_r_p1;
    assign w_edge_g = r_ctl_g_p0 & ~r_ctl_g_p1;
    assign w_edge_y = r_ctl_y_p0 & ~r_ctl_y_p1;

    assign w_ld_r = w_in_cfg & w_edge_r;
    assign w_ld_g = w_in_cfg & w_edge_g & ~w_edge_r;
    assign w_ld_y = w_in_cfg & w_edge_y & ~w_edge_r & ~w_edge_g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl_r_p0 <= 1'b0;
            r_ctl_g_p0 <= 1'b0;
            r_ctl_y_p0 <= 1'b0;
            r_ctl_r_p1 <= 1'b0;
            r_ctl_g_p1 <= 1'b0;
            r_ctl_y_p1 <= 1'b0;
            r_dur_r    <= CNT_W'(R_DEF);
            r_dur_g    <= CNT_W'(G_DEF);
            r_dur_y    <= CNT_W'(Y_DEF);
        end else begin
            r_ctl_r_p0 <= control_r_in;
            r_ctl_g_p0 <= control_g_in;
            r_ctl_y_p0 <= control_y_in;
            r_ctl_r_p1 <= r_ctl_r_p0;
            r_ctl_g_p1 <= r_ctl_g_p0;
            r_ctl_y_p1 <= r_ctl_y_p0;
            if (w_ld_r) r_dur_r <= clamp_dur(dur_in);
            if (w_ld_g) r_dur_g <= clamp_dur(dur_in);
            if (w_ld_y) r_dur_y <= clamp_dur(dur_in);
        end
    end

    // Prescaler restarts on both CONFIG entry and exit so a fresh phase gets a full first second.
    always_comb begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_cfg_change || !w_presc_run) begin
            w_presc_nxt = '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        if (first_in) begin
            w_state_nxt  = S_CONFIG;
            w_remain_nxt = '0;
        end else if (w_in_cfg) begin
            w_state_nxt  = S_RED;
            w_remain_nxt = r_dur_r;
        end else if (w_tick) begin
            if (r_remain > CNT_W'(1)) begin
                w_remain_nxt = r_remain - 1'b1;
            end else begin
                case (r_state)
                    S_RED: begin
                        w_state_nxt  = S_GREEN;
                        w_remain_nxt = r_dur_g;
                    end
                    S_GREEN: begin
                        w_state_nxt  = S_YELLOW;
                        w_remain_nxt = r_dur_y;
                    end
                    default: begin
                        w_state_nxt  = S_RED;
                        w_remain_nxt = r_dur_r;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_lr_nxt = (w_state_nxt == S_RED);
        w_lg_nxt = (w_state_nxt == S_GREEN);
        w_ly_nxt = (w_state_nxt == S_YELLOW) | ((w_state_nxt == S_CONFIG) & w_ly_cfg);
    end

    // Stage boundary: state, countdown and lamps all update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RED;
            r_remain  <= CNT_W'(R_DEF);
            r_presc   <= '0;
            r_light_r <= 1'b1;
            r_light_y <= 1'b0;
            r_light_g <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_remain  <= w_remain_nxt;
            r_presc   <= w_presc_nxt;
            r_light_r <= w_lr_nxt;
            r_light_y <= w_ly_nxt;
            r_light_g <= w_lg_nxt;
        end
    end

    assign light_r   = r_light_r;
    assign light_y   = r_light_y;
    assign light_g   = r_light_g;
    assign remain    = r_remain;
    assign state_out = r_state;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Bench for traffic_light_seq: table of {inputs, cycles, expected outputs} rows fed through a
// scoreboard queue, plus hand-written reset and CONFIG-blink sequences.
module tb_traffic_light_seq;

    localparam int CNT_W = 8;
`ifdef TRAFFIC_BLINK_YELLOW_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam int CF = 0;
    localparam int RD = 1;
    localparam int GR = 2;
    localparam int YL = 3;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LO = 3'b000;

    logic             clk;
    logic             rst;
    logic             first_in;
    logic             control_r_in;
    logic             control_y_in;
    logic             control_g_in;
    logic [CNT_W-1:0] dur_in;
    logic             light_r;
    logic             light_y;
    logic             light_g;
    logic [CNT_W-1:0] remain;
    logic [1:0]       state_out;

    traffic_light_seq #(
        .TICK_DIV(4),
        .CNT_W   (CNT_W),
        .R_DEF   (3),
        .G_DEF   (2),
        .Y_DEF   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .first_in    (first_in),
        .control_r_in(control_r_in),
        .control_y_in(control_y_in),
        .control_g_in(control_g_in),
        .dur_in      (dur_in),
        .light_r     (light_r),
        .light_y     (light_y),
        .light_g     (light_g),
        .remain      (remain),
        .state_out   (state_out)
    );

    typedef struct {
        logic             fi;
        logic             cr;
        logic             cg;
        logic             cy;
        logic [CNT_W-1:0] dur;
        int               n;
        logic [1:0]       st;
        logic [CNT_W-1:0] rem;
        logic [2:0]       lt;
    } vec_t;

    typedef struct {
        logic [1:0]       st;
        logic [CNT_W-1:0] rem;
        logic [2:0]       lt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic fi, input logic cr, input logic cg, input logic cy,
                                input int dur, input int n, input int st, input int rem,
                                input logic [2:0] lt);
        vec_t v;
        v.fi  = fi;
        v.cr  = cr;
        v.cg  = cg;
        v.cy  = cy;
        v.dur = CNT_W'(dur);
        v.n   = n;
        v.st  = 2'(st);
        v.rem = CNT_W'(rem);
        v.lt  = lt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d required %0d", name, idx, act, exp);
        end
    endtask

    task automatic push_exp(input int st, input int rem, input logic [2:0] lt);
        exp_t e;
        e.st  = 2'(st);
        e.rem = CNT_W'(rem);
        e.lt  = lt;
        sb.push_back(e);
    endtask

    // In blink builds the yellow lamp in CONFIG is checked by its own sequence.
    task automatic compare_out(input int idx);
        exp_t       e;
        logic [2:0] m;
        e = sb.pop_front();
        m = (BLINK && e.st == 2'd0) ? 3'b101 : 3'b111;
        check("state",  idx, int'(state_out), int'(e.st));
        check("remain", idx, int'(remain),    int'(e.rem));
        check("lights", idx, int'({light_r, light_y, light_g} & m), int'(e.lt & m));
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        first_in     = v.fi;
        control_r_in = v.cr;
        control_g_in = v.cg;
        control_y_in = v.cy;
        dur_in       = v.dur;
        push_exp(int'(v.st), int'(v.rem), v.lt);
        repeat (v.n) @(posedge clk);
        #1;
        compare_out(idx);
    endtask

    initial begin
        rst          = 1'b0;
        first_in     = 1'b0;
        control_r_in = 1'b0;
        control_y_in = 1'b0;
        control_g_in = 1'b0;
        dur_in       = '0;

        // power-up cycle with defaults R=3 G=2 Y=1 and a 4-clock second
        tbl.push_back(mk(0,0,0,0,0,  0, RD, 3, LR));
        tbl.push_back(mk(0,0,0,0,0,  3, RD, 3, LR));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 2, LR));
        tbl.push_back(mk(0,0,0,0,0,  4, RD, 1, LR));
        tbl.push_back(mk(0,0,0,0,0,  3, RD, 1, LR));
        tbl.push_back(mk(0,0,0,0,0,  1, GR, 2, LG));
        tbl.push_back(mk(0,0,0,0,0,  8, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  3, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 3, LR));
        tbl.push_back(mk(0,0,0,0,0,  6, RD, 2, LR));
        // CONFIG: green := 5
        tbl.push_back(mk(1,0,0,0,0,  1, CF, 0, LO));
        tbl.push_back(mk(1,0,1,0,5,  3, CF, 0, LO));
        tbl.push_back(mk(1,0,0,0,0,  2, CF, 0, LO));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 3, LR));
        tbl.push_back(mk(0,0,0,0,0, 11, RD, 1, LR));
        tbl.push_back(mk(0,0,0,0,0,  1, GR, 5, LG));
        tbl.push_back(mk(0,0,0,0,0, 19, GR, 1, LG));
        tbl.push_back(mk(0,0,0,0,0,  1, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  4, RD, 3, LR));
        // CONFIG: yellow := 0 clamps to 1; then a run-mode red edge with 9 is ignored
        tbl.push_back(mk(1,0,0,0,0,  1, CF, 0, LO));
        tbl.push_back(mk(1,0,0,1,0,  3, CF, 0, LO));
        tbl.push_back(mk(1,0,0,0,0,  2, CF, 0, LO));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 3, LR));
        tbl.push_back(mk(0,1,0,0,9,  3, RD, 3, LR));
        tbl.push_back(mk(0,0,0,0,9,  8, RD, 1, LR));
        tbl.push_back(mk(0,0,0,0,0,  1, GR, 5, LG));
        tbl.push_back(mk(0,0,0,0,0, 20, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  3, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 3, LR));
        // CONFIG: red and yellow edges together with 7 -> only red written
        tbl.push_back(mk(1,0,0,0,0,  1, CF, 0, LO));
        tbl.push_back(mk(1,1,0,1,7,  3, CF, 0, LO));
        tbl.push_back(mk(1,0,0,0,0,  2, CF, 0, LO));
        tbl.push_back(mk(0,0,0,0,0,  1, RD, 7, LR));
        tbl.push_back(mk(0,0,0,0,0, 27, RD, 1, LR));
        tbl.push_back(mk(0,0,0,0,0,  1, GR, 5, LG));
        tbl.push_back(mk(0,0,0,0,0, 20, YL, 1, LY));
        tbl.push_back(mk(0,0,0,0,0,  4, RD, 7, LR));
        tbl.push_back(mk(0,0,0,0,0, 33, GR, 4, LG));

        // asynchronous reset, checked before the first clock edge
        #1 rst = 1'b1;
        #1;
        push_exp(RD, 3, LR);
        compare_out(0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(tbl[i], i + 1);
        end

        // reset mid-GREEN: outputs return without a clock edge, loaded durations are lost
        rst = 1'b1;
        #1;
        push_exp(RD, 3, LR);
        compare_out(100);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_exp(GR, 2, LG);
        repeat (12) @(posedge clk);
        #1;
        compare_out(101);
        push_exp(YL, 1, LY);
        repeat (8) @(posedge clk);
        #1;
        compare_out(102);

`ifdef TRAFFIC_BLINK_YELLOW_EN
        first_in = 1'b1;
        @(posedge clk);
        #1;
        check("blink_entry_y", 200, int'(light_y), 1);
        check("blink_entry_rg", 200, int'({light_r, light_g}), 0);
        repeat (3) @(posedge clk);
        #1;
        check("blink_hold_y", 201, int'(light_y), 1);
        @(posedge clk);
        #1;
        check("blink_tick1_y", 202, int'(light_y), 0);
        repeat (4) @(posedge clk);
        #1;
        check("blink_tick2_y", 203, int'(light_y), 1);
        check("blink_state", 203, int'(state_out), CF);
        first_in = 1'b0;
        push_exp(RD, 3, LR);
        @(posedge clk);
        #1;
        compare_out(204);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
